// File: rtl/gsched_pkg.sv
// Shared types and helpers for the multi-lane global scheduler.
// Holds the controller state encoding, the sys_state codes and a popcount helper.
package gsched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } ctrl_state_t;

    localparam logic [1:0] SYS_IDLE    = 2'd0;
    localparam logic [1:0] SYS_RUN     = 2'd1;
    localparam logic [1:0] SYS_STALLED = 2'd2;
    localparam logic [1:0] SYS_ERROR   = 2'd3;

    localparam int PC_W = 6;

    // Callers zero-extend their lane vector to 32 bits before counting.
    function automatic logic [PC_W-1:0] popcount(input logic [31:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gsched_lane.sv
// One scheduler lane: stall counter, bypass hysteresis and SFTM/DPM enables.
// Control inputs describe the controller state the lane is moving into.
module gsched_lane
    import gsched_pkg::*;
#(
    parameter int CNT_W       = 5,
    parameter int STALL_LIMIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             run,
    input  logic             drain,
    input  logic             clear,
    input  logic             credit,
    input  logic             dpm_busy,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [CNT_W-1:0] hi_thresh,
    input  logic [CNT_W-1:0] lo_thresh,
    output logic             stalled,
    output logic             sftm_en,
    output logic             dpm_en,
    output logic             bypass
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            bypass_q, bypass_d;
    logic            sftm_en_q, sftm_en_d;
    logic            dpm_en_q, dpm_en_d;

    always_comb begin
        stalled     = !credit || (fifo_count >= hi_thresh);
        stall_cnt_d = clear ? '0 : stall_cnt_q;
        bypass_d    = 1'b0;
        sftm_en_d   = 1'b0;
        dpm_en_d    = 1'b0;
        if (run) begin
            bypass_d = bypass_q;
            // Once in bypass only a low FIFO level releases the lane, not credit return.
            if (bypass_q) begin
                if (fifo_count <= lo_thresh) begin
                    bypass_d    = 1'b0;
                    stall_cnt_d = '0;
                end
            end else if (stalled) begin
                if (stall_cnt_q != SC_W'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + SC_W'(1);
                end
                if (stall_cnt_d == SC_W'(STALL_LIMIT)) begin
                    bypass_d = 1'b1;
                end
            end else begin
                stall_cnt_d = '0;
            end
            sftm_en_d = bypass_d || !stalled;
            dpm_en_d  = (fifo_count != '0) || bypass_d;
        end else begin
            sftm_en_d = init;
            dpm_en_d  = drain && ((fifo_count != '0) || dpm_busy);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            bypass_q    <= 1'b0;
            sftm_en_q   <= 1'b0;
            dpm_en_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            bypass_q    <= bypass_d;
            sftm_en_q   <= sftm_en_d;
            dpm_en_q    <= dpm_en_d;
        end
    end

    assign sftm_en = sftm_en_q;
    assign dpm_en  = dpm_en_q;
    assign bypass  = bypass_q;

endmodule

// File: rtl/global_scheduler_mc.sv
// Multi-lane global scheduler: frame control, group counting, prefetch queue and
// sticky overflow detection over NUM_LANES SFTM->FIFO->DPM lanes.
module global_scheduler_mc
    import gsched_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1),
    parameter int STALL_LIMIT = 10,
    parameter int GRP_W       = 16,
    parameter int PF_Q_W      = 3,
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [GRP_W-1:0]           cfg_frame_groups,
    input  logic [CNT_W-1:0]           cfg_hi_thresh,
    input  logic [CNT_W-1:0]           cfg_lo_thresh,
    input  logic [NUM_LANES*CNT_W-1:0] fifo_count,
    input  logic [NUM_LANES-1:0]       credit_available,
    input  logic [NUM_LANES-1:0]       group_done,
    input  logic [NUM_LANES-1:0]       dpm_busy,
    input  logic                       prefetch_busy,
    output logic [NUM_LANES-1:0]       sftm_en,
    output logic [NUM_LANES-1:0]       dpm_en,
    output logic [NUM_LANES-1:0]       bypass,
    output logic                       prefetch_en,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [LANE_W-1:0]          err_lane,
    output logic [1:0]                 sys_state,
    output logic [GRP_W-1:0]           groups_total,
    output logic [31:0]                stall_cycles
);

    localparam int PFS_W = PF_Q_W + PC_W + 1;
    localparam logic [PF_Q_W-1:0] PF_MAX = '1;

    ctrl_state_t         state_q, state_d;
    logic                start_q;
    logic [GRP_W-1:0]    frame_len_q, frame_len_d;
    logic [GRP_W-1:0]    groups_total_q, groups_total_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic [PF_Q_W-1:0]   pf_q_q, pf_q_d;
    logic                prefetch_en_q, prefetch_en_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [LANE_W-1:0]   err_lane_q, err_lane_d;
    logic [1:0]          sys_state_q, sys_state_d;

    logic [PC_W-1:0]      pc;
    logic [GRP_W:0]       grp_sum;
    logic [PFS_W-1:0]     pf_sum;
    logic                 launch, any_err, all_idle, pf_active, pf_fire, any_stalled;
    logic [LANE_W-1:0]    err_idx;
    logic                 lane_init, lane_run, lane_drain;
    logic [NUM_LANES-1:0] lane_stalled;

    always_comb begin
        pc       = popcount(32'(group_done));
        grp_sum  = {1'b0, groups_total_q} + (GRP_W + 1)'(pc);
        any_err  = 1'b0;
        err_idx  = '0;
        all_idle = 1'b1;
        // Scan downward so the lowest offending lane is the one reported.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if ((group_done[i] && (fifo_count[i*CNT_W +: CNT_W] == CNT_W'(FIFO_DEPTH))) ||
                (fifo_count[i*CNT_W +: CNT_W] > CNT_W'(FIFO_DEPTH))) begin
                any_err = 1'b1;
                err_idx = LANE_W'(i);
            end
            if ((fifo_count[i*CNT_W +: CNT_W] != '0) || dpm_busy[i]) begin
                all_idle = 1'b0;
            end
        end
        any_stalled = |lane_stalled;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !start_q) state_d = ST_INIT;
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (grp_sum >= {1'b0, frame_len_q}) state_d = ST_DRAIN;
            ST_DRAIN: if (all_idle) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_ERR;
        endcase
        if (state_q != ST_IDLE && state_q != ST_ERR && any_err) state_d = ST_ERR;
        if (state_q != ST_IDLE && abort) state_d = ST_IDLE;

        launch     = (state_q == ST_IDLE) && (state_d == ST_INIT);
        lane_init  = (state_d == ST_INIT);
        lane_run   = (state_d == ST_RUN);
        lane_drain = (state_d == ST_DRAIN);

        frame_len_d = frame_len_q;
        if (launch) frame_len_d = (cfg_frame_groups == '0) ? GRP_W'(1) : cfg_frame_groups;

        groups_total_d = groups_total_q;
        if (launch) groups_total_d = '0;
        else if (state_q == ST_INIT || state_q == ST_RUN || state_q == ST_DRAIN)
            groups_total_d = grp_sum[GRP_W] ? '1 : grp_sum[GRP_W-1:0];

        stall_cycles_d = stall_cycles_q;
        if (launch) stall_cycles_d = '0;
        else if (lane_run && any_stalled && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 32'd1;

        // Arrivals and launches in the same cycle are netted before saturating.
        pf_active = (state_q == ST_RUN || state_q == ST_DRAIN) &&
                    (state_d == ST_RUN || state_d == ST_DRAIN || state_d == ST_DONE);
        pf_fire   = pf_active && (pf_q_q != '0) && !prefetch_busy;
        pf_sum    = PFS_W'(pf_q_q) + PFS_W'(pc) - PFS_W'(pf_fire);
        pf_q_d    = pf_q_q;
        if (state_d == ST_IDLE) pf_q_d = '0;
        else if (pf_active) pf_q_d = (pf_sum > PFS_W'(PF_MAX)) ? PF_MAX : pf_sum[PF_Q_W-1:0];
        prefetch_en_d = pf_fire;

        busy_d  = (state_d == ST_INIT) || (state_d == ST_RUN) ||
                  (state_d == ST_DRAIN) || (state_d == ST_ERR);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
        err_lane_d = err_lane_q;
        if (state_d == ST_ERR && state_q != ST_ERR) err_lane_d = err_idx;

        case (state_d)
            ST_RUN:            sys_state_d = any_stalled ? SYS_STALLED : SYS_RUN;
            ST_INIT, ST_DRAIN: sys_state_d = SYS_RUN;
            ST_ERR:            sys_state_d = SYS_ERROR;
            default:           sys_state_d = SYS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            frame_len_q    <= '0;
            groups_total_q <= '0;
            stall_cycles_q <= '0;
            pf_q_q         <= '0;
            prefetch_en_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_lane_q     <= '0;
            sys_state_q    <= SYS_IDLE;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            frame_len_q    <= frame_len_d;
            groups_total_q <= groups_total_d;
            stall_cycles_q <= stall_cycles_d;
            pf_q_q         <= pf_q_d;
            prefetch_en_q  <= prefetch_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_lane_q     <= err_lane_d;
            sys_state_q    <= sys_state_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        gsched_lane #(
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .init       (lane_init),
            .run        (lane_run),
            .drain      (lane_drain),
            .clear      (launch),
            .credit     (credit_available[g]),
            .dpm_busy   (dpm_busy[g]),
            .fifo_count (fifo_count[g*CNT_W +: CNT_W]),
            .hi_thresh  (cfg_hi_thresh),
            .lo_thresh  (cfg_lo_thresh),
            .stalled    (lane_stalled[g]),
            .sftm_en    (sftm_en[g]),
            .dpm_en     (dpm_en[g]),
            .bypass     (bypass[g])
        );
    end

    assign prefetch_en  = prefetch_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_lane     = err_lane_q;
    assign sys_state    = sys_state_q;
    assign groups_total = groups_total_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_global_scheduler_mc.sv
// Directed self-checking bench for global_scheduler_mc with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_global_scheduler_mc;

    localparam int NL = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, prefetch_busy;
    logic [15:0]   cfg_frame_groups;
    logic [CW-1:0] cfg_hi_thresh, cfg_lo_thresh;
    logic [NL*CW-1:0] fifo_count;
    logic [NL-1:0] credit_available, group_done, dpm_busy;
    logic [NL-1:0] sftm_en, dpm_en, bypass;
    logic          prefetch_en, busy, done, error;
    logic [1:0]    err_lane, sys_state;
    logic [15:0]   groups_total;
    logic [31:0]   stall_cycles;

    int total = 0;
    int bad   = 0;
    int pulses;

    global_scheduler_mc dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_frame_groups (cfg_frame_groups),
        .cfg_hi_thresh    (cfg_hi_thresh),
        .cfg_lo_thresh    (cfg_lo_thresh),
        .fifo_count       (fifo_count),
        .credit_available (credit_available),
        .group_done       (group_done),
        .dpm_busy         (dpm_busy),
        .prefetch_busy    (prefetch_busy),
        .sftm_en          (sftm_en),
        .dpm_en           (dpm_en),
        .bypass           (bypass),
        .prefetch_en      (prefetch_en),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_lane         (err_lane),
        .sys_state        (sys_state),
        .groups_total     (groups_total),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NL-1:0] gd);
        group_done = gd;
        step(1);
        group_done = '0;
    endtask

    task automatic setCount(input int lane, input logic [CW-1:0] v);
        fifo_count[lane*CW +: CW] = v;
    endtask

    task automatic launchFrame(input logic [15:0] len);
        cfg_frame_groups = len;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prefetch_busy = 1'b0;
        cfg_frame_groups = 16'd0; cfg_hi_thresh = 5'd12; cfg_lo_thresh = 5'd4;
        fifo_count = '0; credit_available = 4'hF; group_done = '0; dpm_busy = '0;
        step(2);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sftm", 32'(sftm_en), 32'd0);
        checkOutput("rst_sys", 32'(sys_state), 32'd0);
        rst = 1'b0;
        step(1);

        // Basic frame of 4 groups
        cfg_frame_groups = 16'd4;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checkOutput("init_busy", 32'(busy), 32'd1);
        checkOutput("init_sftm", 32'(sftm_en), 32'hF);
        checkOutput("init_dpm", 32'(dpm_en), 32'h0);
        step(1);
        setCount(0, 5'd1); setCount(1, 5'd2); setCount(2, 5'd3); setCount(3, 5'd1);
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        applyStimulus(4'b0100);
        checkOutput("basic_grp3", 32'(groups_total), 32'd3);
        checkOutput("basic_run_sftm", 32'(sftm_en), 32'hF);
        checkOutput("basic_run_dpm", 32'(dpm_en), 32'hF);
        applyStimulus(4'b1000);
        checkOutput("basic_grp4", 32'(groups_total), 32'd4);
        checkOutput("basic_drain_sftm", 32'(sftm_en), 32'h0);
        checkOutput("basic_drain_dpm", 32'(dpm_en), 32'hF);
        fifo_count = '0;
        step(1);
        checkOutput("basic_done", 32'(done), 32'd1);
        checkOutput("basic_busy_low", 32'(busy), 32'd0);
        step(1);
        checkOutput("basic_done_pulse", 32'(done), 32'd0);

        // All lanes finish a group in the same cycle; start held high throughout
        cfg_frame_groups = 16'd3;
        start = 1'b1;
        step(2);
        for (int i = 0; i < NL; i++) setCount(i, 5'd2);
        applyStimulus(4'hF);
        checkOutput("simul_grp", 32'(groups_total), 32'd4);
        checkOutput("simul_drain_sftm", 32'(sftm_en), 32'h0);
        checkOutput("simul_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            checkOutput($sformatf("simul_pf%0d", k), 32'(prefetch_en), (k < 4) ? 32'd1 : 32'd0);
        end
        fifo_count = '0;
        step(1);
        checkOutput("simul_done", 32'(done), 32'd1);
        step(2);
        checkOutput("held_start_no_relaunch", 32'(busy), 32'd0);
        start = 1'b0;
        step(1);

        // Lane 2 loses credit for 10 cycles and enters bypass
        launchFrame(16'd100);
        credit_available = 4'b1011;
        step(9);
        checkOutput("byp_c9_bypass", 32'(bypass), 32'h0);
        checkOutput("byp_c9_sftm", 32'(sftm_en), 32'b1011);
        checkOutput("byp_c9_sys", 32'(sys_state), 32'd2);
        step(1);
        checkOutput("byp_c10_bypass", 32'(bypass), 32'b0100);
        checkOutput("byp_c10_sftm", 32'(sftm_en), 32'hF);
        checkOutput("byp_c10_dpm", 32'(dpm_en), 32'b0100);
        credit_available = 4'hF;
        setCount(2, 5'd8);
        step(1);
        checkOutput("byp_hold8", 32'(bypass), 32'b0100);
        checkOutput("byp_hold_sys", 32'(sys_state), 32'd1);
        setCount(2, 5'd4);
        step(1);
        checkOutput("byp_exit4", 32'(bypass), 32'h0);
        checkOutput("byp_exit_dpm", 32'(dpm_en), 32'b0100);
        checkOutput("byp_stall_cycles", stall_cycles, 32'd10);
        fifo_count = '0;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("byp_abort_busy", 32'(busy), 32'd0);

        // Writes into full FIFOs on lanes 1 and 3 in the same cycle
        launchFrame(16'd100);
        setCount(1, 5'd16); setCount(3, 5'd16);
        applyStimulus(4'b1010);
        fifo_count = '0;
        checkOutput("ovf_error", 32'(error), 32'd1);
        checkOutput("ovf_lane", 32'(err_lane), 32'd1);
        checkOutput("ovf_sys", 32'(sys_state), 32'd3);
        checkOutput("ovf_enables", 32'({sftm_en, dpm_en}), 32'h0);
        checkOutput("ovf_busy", 32'(busy), 32'd1);
        step(2);
        checkOutput("ovf_sticky", 32'(error), 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("ovf_abort_error", 32'(error), 32'd0);
        checkOutput("ovf_abort_done", 32'(done), 32'd0);
        checkOutput("ovf_abort_sys", 32'(sys_state), 32'd0);

        // Nine groups queue up behind a busy prefetcher
        launchFrame(16'd100);
        for (int i = 0; i < NL; i++) setCount(i, 5'd1);
        prefetch_busy = 1'b1;
        applyStimulus(4'hF);
        applyStimulus(4'hF);
        applyStimulus(4'b0001);
        step(17);
        checkOutput("pf_blocked", 32'(prefetch_en), 32'd0);
        checkOutput("pf_grp9", 32'(groups_total), 32'd9);
        prefetch_busy = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (prefetch_en) pulses++;
        end
        checkOutput("pf_pulses", 32'(pulses), 32'd7);
        fifo_count = '0;
        abort = 1'b1;
        step(1);
        abort = 1'b0;

        // Asynchronous reset in the middle of RUN
        launchFrame(16'd100);
        setCount(0, 5'd1);
        credit_available = 4'b1110;
        applyStimulus(4'b0001);
        step(2);
        checkOutput("rst_pre_sys", 32'(sys_state), 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_sys", 32'(sys_state), 32'd0);
        checkOutput("rst_mid_grp", 32'(groups_total), 32'd0);
        checkOutput("rst_mid_stall", stall_cycles, 32'd0);
        credit_available = 4'hF;
        fifo_count = '0;
        step(1);
        rst = 1'b0;
        step(1);

        // Zero frame length means one group; abort while draining
        launchFrame(16'd0);
        for (int i = 0; i < NL; i++) setCount(i, 5'd3);
        applyStimulus(4'b0001);
        checkOutput("drain_len0_sftm", 32'(sftm_en), 32'h0);
        checkOutput("drain_len0_dpm", 32'(dpm_en), 32'hF);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("drain_abort_busy", 32'(busy), 32'd0);
        checkOutput("drain_abort_dpm", 32'(dpm_en), 32'h0);
        checkOutput("drain_abort_grp", 32'(groups_total), 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("drain_abort_nodone%0d", k), 32'(done), 32'd0);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/global_scheduler_mc.md
Name: global_scheduler_mc

Overview:
- Multi-lane successor to the single-stream global controller.
- Schedules NUM_LANES independent SFTM→FIFO→DPM lanes plus one shared prefetcher.
- Adds frame-length completion, per-lane adaptive bypass with hysteresis, queued prefetch requests, and a sticky lane-tagged overflow error.
- Sits between the top-level start/status interface and the per-lane datapath enables.

Parameters:
- NUM_LANES, 4, number of SFTM/FIFO/DPM lanes.
- FIFO_DEPTH, 16, entries per lane FIFO.
- CNT_W, $clog2(FIFO_DEPTH+1), fifo_count field width.
- STALL_LIMIT, 10, consecutive lane stall cycles before bypass entry.
- GRP_W, 16, width of group counters and frame length.
- PF_Q_W, 3, width of the pending-prefetch counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; a rising edge seen in IDLE launches a frame
- abort  in  1  pulse; forces the return to IDLE
- cfg_frame_groups  in  GRP_W  groups per frame, sampled on launch; 0 is treated as 1
- cfg_hi_thresh  in  CNT_W  FIFO high-water mark
- cfg_lo_thresh  in  CNT_W  FIFO low-water mark; must be < cfg_hi_thresh
- fifo_count  in  NUM_LANES*CNT_W  packed per-lane occupancy; lane i is at bits [i*CNT_W +: CNT_W]
- credit_available  in  NUM_LANES  per-lane downstream credit
- group_done  in  NUM_LANES  per-lane one-cycle group-produced pulse
- dpm_busy  in  NUM_LANES  per-lane DPM processing
- prefetch_busy  in  1  prefetcher busy
- sftm_en  out  NUM_LANES  per-lane SFTM enable
- dpm_en  out  NUM_LANES  per-lane DPM enable
- bypass  out  NUM_LANES  per-lane bypass mode
- prefetch_en  out  1  one-cycle prefetch launch pulse
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- error  out  1  sticky overflow flag
- err_lane  out  $clog2(NUM_LANES)  lowest lane index that caused the error
- sys_state  out  2  0 = idle, 1 = running, 2 = stalled, 3 = error
- groups_total  out  GRP_W  groups counted in the current frame
- stall_cycles  out  32  cycles in RUN with at least one lane stalled

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; all counters are 0. Every output is registered, so the response lands one cycle after its cause.
- Top-level FSM states: IDLE, INIT, RUN, DRAIN, DONE, ERR.
- IDLE → INIT on a start rising edge. On this transition:
  - latch cfg_frame_groups;
  - clear groups_total, stall_cycles, and every lane stall/bypass state;
  - assert busy.
- INIT → RUN after 1 cycle. In INIT, sftm_en is all 1s and dpm_en is all 0s.
- RUN, per lane i:
  - Lane i is stalled when !credit_available[i] or fifo_count[i] >= cfg_hi_thresh.
  - Stalled lane: sftm_en[i] = 0 and its stall counter increments. Otherwise sftm_en[i] = 1 and the counter clears.
  - Bypass entry: when the stall counter reaches STALL_LIMIT, bypass[i] goes to 1 and sftm_en[i] is forced to 1.
  - Bypass exit: only when fifo_count[i] <= cfg_lo_thresh. Exit clears bypass[i] and the stall counter (hysteresis).
  - dpm_en[i] = (fifo_count[i] != 0) || bypass[i].
- sys_state in RUN: 2 if any lane is stalled, else 1. stall_cycles increments on the same condition and saturates at all 1s.
- Group counting: each cycle, groups_total += popcount(group_done). Multiple lanes in the same cycle all count. The addition saturates at all 1s.
- RUN → DRAIN once groups_total + popcount >= latched frame length. The check uses the same-cycle sum.
- DRAIN:
  - sftm_en = 0 and bypass = 0.
  - dpm_en[i] stays 1 while fifo_count[i] != 0 or dpm_busy[i].
  - DRAIN → DONE when all lanes are empty and idle.
- DONE: one cycle; done = 1 and busy = 0; then → IDLE. A start held high must drop and rise again to relaunch.
- Prefetch queue:
  - Pending counter pf_q += popcount(group_done), saturating at 2^PF_Q_W - 1.
  - When pf_q != 0 and !prefetch_busy, prefetch_en pulses and pf_q decrements in the same cycle; increment and decrement are netted.
  - The queue is active in RUN and DRAIN and is cleared on entry to IDLE.
- Error detection:
  - Condition: group_done[i] while fifo_count[i] == FIFO_DEPTH (write into a full FIFO), or fifo_count[i] > FIFO_DEPTH.
  - Checked in any state other than IDLE.
  - Response: → ERR; error = 1; err_lane = lowest offending lane; sys_state = 3; all enables 0; busy stays 1.
- ERR is left only by abort or rst. abort moves the FSM to IDLE and clears error.
- abort in any non-IDLE state → IDLE next cycle with all enables, busy and bypass at 0. No done pulse is produced. Counters hold their values until the next launch.
- Simultaneous events: abort outranks error; error outranks the DRAIN transition.
- rst mid-frame: immediate asynchronous return to reset values.

Decomposition:
- Shared package gsched_pkg holds:
  - ctrl_state_t enum (IDLE..ERR);
  - SYS_IDLE/RUN/STALLED/ERROR 2-bit codes;
  - a popcount function.
- One sub-module, gsched_lane: per-lane stall counter, bypass hysteresis, and sftm_en/dpm_en generation. It is instantiated NUM_LANES times through generate, with inputs run, drain and clear.

Test Plan:
- Basic frame:
  - Stimulus: frame length 4; lanes 0–3 each pulse group_done once with counts 1..3; credits high.
  - Response: DRAIN entered on the 4th group; after FIFOs reach 0, done pulses once; groups_total = 4; busy falls.
- Simultaneous groups:
  - Stimulus: all 4 lanes pulse group_done in one cycle with frame length 3.
  - Response: groups_total = 4; DRAIN next cycle; pf_q = 4, then 4 prefetch_en pulses on consecutive cycles with prefetch_busy low.
- Bypass hysteresis:
  - Stimulus: lane 2 credit low for 10 cycles, hi = 12, lo = 4.
  - Response: bypass[2] = 1 on cycle 11. Count driven 8 → bypass held; driven 4 → bypass cleared next cycle. Other lanes are unaffected.
- Overflow:
  - Stimulus: lane 1 fifo_count = 16 with group_done[1] = 1.
  - Response: next cycle error = 1, err_lane = 1, sys_state = 3, enables 0. Then abort → IDLE, error = 0, no done pulse.
- Prefetch back-pressure:
  - Stimulus: prefetch_busy high for 20 cycles while 9 groups arrive (PF_Q_W = 3).
  - Response: pf_q saturates at 7; exactly 7 pulses follow after busy drops.
- Reset/abort mid-RUN:
  - Stimulus: assert rst during RUN; separately, assert abort during DRAIN.
  - Response: rst gives all outputs 0 immediately. abort gives IDLE next cycle with busy = 0 and done never asserted.
